sram64x32_port_arbiter: RTL and testbench

- Shares one single-port 64x32 SRAM macro (clk, we, addr[5:0], din[31:0], registered dout[31:0]) between two requesters, A and B.
- Uses valid/ready request handshakes, round-robin arbitration and fixed 1-cycle read latency.
- After reset, writes INIT_VALUE to every word before accepting requests, because the macro powers up with undefined contents.
- Sits between the macro and client logic in the top level.

---
 rtl/sram64x32_port_arbiter.sv | 127 ++++++++++++
 tb/tb_sram64x32_port_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sram64x32_port_arbiter.sv
// rtl/sram64x32_port_arbiter.sv - two-port round-robin arbiter with post-reset clear sweep for a 64x32 SRAM macro
module sram64x32_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter bit INIT_ENABLE = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  init_done,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_B = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
    logic                  prio_q, prio_d;
    logic                  init_done_q, init_done_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;

    logic run;
    logic a_grant, b_grant;

    always_comb begin
        run     = (state_q == ST_RUN);
        a_grant = run & a_valid & (~b_valid | (prio_q == PRIO_A));
        b_grant = run & b_valid & (~a_valid | (prio_q == PRIO_B));
    end

    // SRAM drive: sweep during INIT, granted port in RUN, idle read of address 0 otherwise
    always_comb begin
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        if (!run) begin
            sram_we   = 1'b1;
            sram_addr = init_cnt_q;
            sram_din  = INIT_VALUE;
        end else if (a_grant) begin
            sram_we   = a_we;
            sram_addr = a_addr;
            sram_din  = a_din;
        end else if (b_grant) begin
            sram_we   = b_we;
            sram_addr = b_addr;
            sram_din  = b_din;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        prio_d      = prio_q;
        a_rvalid_d  = a_grant & ~a_we;
        b_rvalid_d  = b_grant & ~b_we;
        if (!run) begin
            if (init_cnt_q == LAST_ADDR) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end
        if (a_grant) begin
            prio_d = PRIO_B;
        end else if (b_grant) begin
            prio_d = PRIO_A;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_ENABLE ? ST_INIT : ST_RUN;
            init_cnt_q  <= '0;
            prio_q      <= PRIO_A;
            init_done_q <= ~INIT_ENABLE;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            prio_q      <= prio_d;
            init_done_q <= init_done_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
        end
    end

    // Both ports see the macro output; only rvalid says whose read it is
    always_comb begin
        a_ready   = a_grant;
        b_ready   = b_grant;
        a_rvalid  = a_rvalid_q;
        b_rvalid  = b_rvalid_q;
        a_rdata   = sram_dout;
        b_rdata   = sram_dout;
        init_done = init_done_q;
    end

endmodule

// File: tb/tb_sram64x32_port_arbiter.sv
// tb/tb_sram64x32_port_arbiter.sv - directed self-checking bench for sram64x32_port_arbiter
module tb_sram64x32_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, a_we = 1'b0;
    logic [5:0]  a_addr = '0;
    logic [31:0] a_din = '0;
    logic        b_valid = 1'b0, b_we = 1'b0;
    logic [5:0]  b_addr = '0;
    logic [31:0] b_din = '0;
    logic        a_ready, a_rvalid, b_ready, b_rvalid, init_done;
    logic [31:0] a_rdata, b_rdata;
    logic        sram_we;
    logic [5:0]  sram_addr;
    logic [31:0] sram_din, sram_dout;

    logic [31:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural model of the single-port macro with registered dout
    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    sram64x32_port_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .init_done(init_done),
        .sram_we(sram_we), .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs are driven at edge+1, outputs checked at edge+2
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        tick();
        tick();
        settle();
        chk("reset_state", {62'(0), init_done, a_rvalid}, 64'h0);
        chk("reset_drive", {b_rvalid, a_ready, b_ready, sram_we, sram_addr}, {1'b0, 1'b0, 1'b0, 1'b1, 6'd0});

        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            settle();
            chk($sformatf("sweep_%0d", i), {sram_we, sram_addr, sram_din, init_done, a_ready},
                {1'b1, 6'(i), 32'h0, 1'b0, 1'b0});
            tick();
        end
        settle();
        chk("init_done_rise", {init_done, sram_we, sram_addr}, {1'b1, 1'b0, 6'd0});

        a_valid = 1; a_we = 0; a_addr = 6'd17; settle();
        chk("rd17_grant", {a_ready, b_ready, sram_we, sram_addr}, {1'b1, 1'b0, 1'b0, 6'd17});
        tick(); a_valid = 0; settle();
        chk("rd17_data", {a_rvalid, b_rvalid, a_rdata}, {1'b1, 1'b0, 32'h0});
        tick(); settle();
        chk("rd17_rvalid_drop", {a_rvalid, b_rvalid}, 2'b00);

        a_valid = 1; a_we = 1; a_addr = 6'd5; a_din = 32'hDEADBEEF; settle();
        chk("wr5_grant", {a_ready, sram_we, sram_addr, sram_din}, {1'b1, 1'b1, 6'd5, 32'hDEADBEEF});
        tick(); a_we = 0; settle();
        chk("rd5_grant_no_wr_rvalid", {a_ready, a_rvalid, sram_we}, {1'b1, 1'b0, 1'b0});
        tick(); a_valid = 0; settle();
        chk("rd5_data", {a_rvalid, b_rvalid, a_rdata}, {1'b1, 1'b0, 32'hDEADBEEF});

        a_valid = 1; a_we = 1; a_addr = 6'd1; a_din = 32'h11111111;
        tick(); a_valid = 0;
        b_valid = 1; b_we = 1; b_addr = 6'd2; b_din = 32'h22222222; settle();
        chk("b_wr2_grant", {b_ready, a_ready, sram_we, sram_addr, sram_din}, {1'b1, 1'b0, 1'b1, 6'd2, 32'h22222222});
        tick(); b_we = 0; b_addr = 6'd2;
        a_valid = 1; a_we = 0; a_addr = 6'd1; settle();
        chk("rr0", {a_ready, b_ready, sram_addr, b_rvalid}, {1'b1, 1'b0, 6'd1, 1'b0});
        tick(); settle();
        chk("rr1", {a_ready, b_ready, sram_addr, a_rvalid, b_rvalid, a_rdata}, {1'b0, 1'b1, 6'd2, 1'b1, 1'b0, 32'h11111111});
        tick(); settle();
        chk("rr2", {a_ready, b_ready, sram_addr, a_rvalid, b_rvalid, b_rdata}, {1'b1, 1'b0, 6'd1, 1'b0, 1'b1, 32'h22222222});
        tick(); settle();
        chk("rr3", {a_ready, b_ready, sram_addr, a_rvalid, b_rvalid, a_rdata}, {1'b0, 1'b1, 6'd2, 1'b1, 1'b0, 32'h11111111});
        tick(); a_valid = 0; b_valid = 0; settle();
        chk("rr4", {a_rvalid, b_rvalid, b_rdata}, {1'b0, 1'b1, 32'h22222222});

        // Lone A read hands priority to B for the collision that follows
        a_valid = 1; a_we = 0; a_addr = 6'd5;
        tick();
        b_valid = 1; b_we = 1; b_addr = 6'd63; b_din = 32'h12345678; a_addr = 6'd63; settle();
        chk("col_b_first", {b_ready, a_ready, sram_we, sram_addr, sram_din}, {1'b1, 1'b0, 1'b1, 6'd63, 32'h12345678});
        chk("col_prev_rd5", {a_rvalid, a_rdata}, {1'b1, 32'hDEADBEEF});
        tick(); b_valid = 0; settle();
        chk("col_a_next", {a_ready, b_ready, sram_we, sram_addr, b_rvalid}, {1'b1, 1'b0, 1'b0, 6'd63, 1'b0});
        tick(); settle();
        chk("col_raw_data", {a_rvalid, a_rdata}, {1'b1, 32'h12345678});

        // a_valid still high: its read of 63 is in flight when reset hits mid-RUN
        tick(); settle();
        chk("pre_rst_rvalid", {a_rvalid}, 1'b1);
        rst = 1; settle();
        chk("rst_run_async", {a_rvalid, b_rvalid, init_done, a_ready, sram_we, sram_addr}, {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0});
        tick(); rst = 0;
        for (int i = 0; i < 30; i++) tick();
        settle();
        chk("mid_init_addr30", {sram_we, sram_addr, a_ready}, {1'b1, 6'd30, 1'b0});
        rst = 1; settle();
        chk("rst_init_async", {sram_addr, init_done}, {6'd0, 1'b0});
        tick(); rst = 0;
        for (int i = 0; i < 64; i++) begin
            settle();
            chk($sformatf("resweep_%0d", i), {sram_we, sram_addr, init_done, a_ready},
                {1'b1, 6'(i), 1'b0, 1'b0});
            tick();
        end
        settle();
        chk("held_req_grant", {init_done, a_ready, sram_we, sram_addr}, {1'b1, 1'b1, 1'b0, 6'd63});
        tick(); a_valid = 0; settle();
        chk("held_req_data_cleared", {a_rvalid, a_rdata}, {1'b1, 32'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
